rf_window_scheduler: RTL and testbench

//  Sequences the 128 receptive-field windows (64 taps, stride 8) of the padded 1080-sample signal

---
 rtl/rf_window_scheduler_if.sv | 27 ++
 rtl/rf_window_scheduler.sv | 149 ++++++++++++++
 tb/tb_rf_window_scheduler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_window_scheduler_if.sv
// Handshake bundle between the layer controller, the window scheduler and the CU array.
// The scheduler uses the slave modport; the controller/CU side uses master.
interface rf_window_scheduler_if #(
  parameter int NUM_CU = 4,
  parameter int ADDR_W = 11
);
  logic              start;
  logic              abort;
  logic [NUM_CU-1:0] cu_done;
  logic [NUM_CU-1:0] cu_start;
  logic [ADDR_W-1:0] win_addr;
  logic [7:0]        win_idx;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       perf_cycles;

  modport master (
    output start, abort, cu_done,
    input  cu_start, win_addr, win_idx, busy, done, err, perf_cycles
  );

  modport slave (
    input  start, abort, cu_done,
    output cu_start, win_addr, win_idx, busy, done, err, perf_cycles
  );
endinterface

// File: rtl/rf_window_scheduler.sv
// Round-robin dispatcher of receptive-field windows onto a pool of convolution units.
// Optional feature macro RF_SCHED_PERF_EN builds the frame cycle counter behind perf_cycles.
module rf_window_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int W          = 1024,
  parameter int P          = 28,
  parameter int F          = 64,
  parameter int STRIDE     = 8,
  parameter int NUM_WIN    = 128,
  parameter int NUM_CU     = 4,
  parameter int ADDR_W     = 11
) (
  input logic                  clk,
  input logic                  reset,
  rf_window_scheduler_if.slave bus
);

  localparam int PTR_W    = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;
  localparam int LAST_TAP = (NUM_WIN - 1) * STRIDE + F - 1;
  // Geometry sanity term; DATA_WIDTH and the padding only describe the frame.
  localparam bit unused_cfg_ok = (LAST_TAP <= W + 2 * P - 1) && (DATA_WIDTH > 0);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [NUM_CU-1:0] cu_busy;
  logic [7:0]        win_cnt;
  logic [PTR_W-1:0]  ptr;

  logic [NUM_CU-1:0] cu_start_q;
  logic [ADDR_W-1:0] win_addr_q;
  logic [7:0]        win_idx_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              found;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand;
  logic [NUM_CU-1:0] grant_fire;
  logic              dispatch_go;
  logic              last_win;
  logic              start_acc;
  logic              spurious;

  // First free CU at or above the pointer, wrapping modulo NUM_CU.
  // cu_busy is still set in the cycle a cu_done arrives, so a CU is never regranted that cycle.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = ptr;
    for (int i = 0; i < NUM_CU; i++) begin
      if (!found && !cu_busy[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
      cand = (cand == PTR_W'(NUM_CU - 1)) ? '0 : cand + PTR_W'(1);
    end
  end

  assign dispatch_go = (state == S_DISPATCH) && found && !bus.abort;
  assign grant_fire  = dispatch_go ? (NUM_CU'(1) << grant_idx) : '0;
  assign last_win    = (win_cnt == 8'(NUM_WIN - 1));
  assign start_acc   = (state == S_IDLE) && bus.start && !bus.abort;
  assign spurious    = |(bus.cu_done & ~cu_busy);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (bus.start) state_nxt = S_DISPATCH;
      S_DISPATCH: if (dispatch_go && last_win) state_nxt = S_DRAIN;
      S_DRAIN:    if (cu_busy == '0) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (bus.abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cu_busy    <= '0;
      win_cnt    <= '0;
      ptr        <= '0;
      cu_start_q <= '0;
      win_addr_q <= '0;
      win_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;

      // A fresh frame and an abort both forget every outstanding CU.
      if (start_acc || bus.abort) cu_busy <= '0;
      else                        cu_busy <= (cu_busy & ~bus.cu_done) | grant_fire;

      if (start_acc) begin
        win_cnt <= '0;
        ptr     <= '0;
      end else if (dispatch_go) begin
        win_cnt <= win_cnt + 8'd1;
        ptr     <= (grant_idx == PTR_W'(NUM_CU - 1)) ? '0 : grant_idx + PTR_W'(1);
      end

      cu_start_q <= grant_fire;
      if (dispatch_go) begin
        win_idx_q  <= win_cnt;
        win_addr_q <= ADDR_W'(win_cnt) * ADDR_W'(STRIDE);
      end

      busy_q <= (state_nxt == S_DISPATCH) || (state_nxt == S_DRAIN);
      done_q <= (state_nxt == S_DONE);

      if (start_acc)     err_q <= 1'b0;
      else if (spurious) err_q <= 1'b1;
    end
  end

`ifdef RF_SCHED_PERF_EN
  logic [31:0] perf_q;

  // Counts the acceptance edge plus every edge leaving DISPATCH/DRAIN, so the DONE edge is included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= 32'd1;
    end else if (!bus.abort && ((state == S_DISPATCH) || (state == S_DRAIN))) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

  assign bus.cu_start = cu_start_q;
  assign bus.win_addr = win_addr_q;
  assign bus.win_idx  = win_idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_rf_window_scheduler.sv
// Directed bench for rf_window_scheduler: a cycle-stepped CU model with per-CU latency,
// frame recording, and per-scenario checks against hand-derived expectations.
`timescale 1ns/1ps
module tb_rf_window_scheduler;
  localparam int NUM_CU  = 4;
  localparam int ADDR_W  = 11;
  localparam int NUM_WIN = 128;
  localparam int MAX_CYC = 4000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rf_window_scheduler_if #(.NUM_CU(NUM_CU), .ADDR_W(ADDR_W)) bus ();
  rf_window_scheduler #(.NUM_CU(NUM_CU), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Frame configuration and recorded observations
  int lat [NUM_CU];
  int stop_mode, stop_idx, spur_t;
  int grant_cu [NUM_WIN];
  int grant_t  [NUM_WIN];
  int n_grants, n_order_bad, n_addr_bad, n_multi, n_overlap, n_done, done_t, n_perf_nz, stop_t;
  int n_start_after, n_done_after;
  logic [ADDR_W-1:0] last_addr;
  logic e0_start_zero, e0_busy, e0_err, busy_at_done, busy_before_done, done_after, err_at_done;
  logic err_pre, err_post, busy_after_abort, err_end, rst_zero1, rst_zero2, timeout;
  logic [31:0] perf_at_done, perf_after_done;

  function automatic logic outs_zero();
    return (bus.cu_start == '0) && (bus.win_addr == '0) && (bus.win_idx == 8'd0) && !bus.busy &&
           !bus.done && !bus.err && (bus.perf_cycles == 32'd0);
  endfunction

  task automatic run_frame();
    logic [NUM_CU-1:0] cs, tb_busy, drv_done, sampled;
    int rem [NUM_CU];
    logic prev_busy;
    n_grants = 0; n_order_bad = 0; n_addr_bad = 0; n_multi = 0; n_overlap = 0; n_done = 0;
    done_t = -1; n_perf_nz = 0; stop_t = -1; n_start_after = 0; n_done_after = 0;
    tb_busy = '0; drv_done = '0; prev_busy = 1'b0; timeout = 1'b1;
    err_pre = 1'bx; err_post = 1'bx; last_addr = '0;
    for (int k = 0; k < NUM_CU; k++) rem[k] = 0;
    for (int i = 0; i < NUM_WIN; i++) begin grant_cu[i] = -1; grant_t[i] = -1; end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int t = 0; t < MAX_CYC; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      cs = bus.cu_start;
      sampled = drv_done;
      if (t == 0) begin e0_start_zero = (cs == '0); e0_busy = bus.busy; e0_err = bus.err; end
      if (bus.perf_cycles != 32'd0) n_perf_nz++;
      if (t == spur_t - 1) err_pre = bus.err;
      if (t == spur_t) err_post = bus.err;
      if (stop_t >= 0 && t > stop_t) begin
        if (cs != '0) n_start_after++;
        if (bus.done) n_done_after++;
      end
      if (cs != '0) begin
        if (!$onehot(cs)) n_multi++;
        if ((cs & tb_busy) != '0) n_overlap++;
        if (n_grants < NUM_WIN) begin
          for (int k = 0; k < NUM_CU; k++) if (cs[k]) grant_cu[n_grants] = k;
          grant_t[n_grants] = t;
        end
        if (bus.win_idx != 8'(n_grants)) n_order_bad++;
        if (bus.win_addr != ADDR_W'(n_grants * 8)) n_addr_bad++;
        if (n_grants == NUM_WIN - 1) last_addr = bus.win_addr;
        n_grants++;
      end
      if (bus.done) begin
        n_done++;
        if (done_t < 0) begin
          done_t = t; perf_at_done = bus.perf_cycles; busy_at_done = bus.busy;
          busy_before_done = prev_busy; err_at_done = bus.err;
        end
      end
      if (done_t >= 0 && t == done_t + 1) begin
        perf_after_done = bus.perf_cycles; done_after = bus.done; timeout = 1'b0;
        break;
      end
      prev_busy = bus.busy;
      if (stop_mode != 0 && stop_t < 0 && cs != '0 && bus.win_idx == 8'(stop_idx)) begin
        stop_t = t;
        if (stop_mode == 1) begin
          reset = 1'b1; bus.cu_done = '0;
          #1 rst_zero1 = outs_zero();
          @(posedge clk); @(posedge clk); #1;
          rst_zero2 = outs_zero();
          reset = 1'b0; timeout = 1'b0;
          return;
        end
        bus.abort = 1'b1;
      end
      if (stop_mode == 2 && stop_t >= 0 && t == stop_t + 1) begin
        bus.abort = 1'b0; busy_after_abort = bus.busy;
      end
      if (stop_mode == 2 && stop_t >= 0 && t == stop_t + 12) begin
        err_end = bus.err; timeout = 1'b0;
        break;
      end
      // CU model: done is sampled exactly lat[k] edges after the edge that launched the CU
      tb_busy = (tb_busy & ~sampled) | cs;
      for (int k = 0; k < NUM_CU; k++) if (rem[k] > 0) rem[k]--;
      for (int k = 0; k < NUM_CU; k++) if (cs[k]) rem[k] = lat[k];
      for (int k = 0; k < NUM_CU; k++) drv_done[k] = (rem[k] == 1);
      bus.cu_done = drv_done | ((t == spur_t - 1) ? NUM_CU'(1) : NUM_CU'(0));
    end
    bus.cu_done = '0;
    bus.abort = 1'b0;
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    stop_mode = 0; stop_idx = 0; spur_t = -10;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (outs_zero() !== 1'b1) begin errors++; $display("FAIL reset_outputs: got busy=%0b err=%0b cu_start=%0h want all 0", bus.busy, bus.err, bus.cu_start); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.cu_start !== 4'h0) begin errors++; $display("FAIL reset_idle_cu_start: got %0h want 0", bus.cu_start); end
  endtask

  task automatic test_basic();
    int rr_bad;
    set_lat(3, 3, 3, 3);
    run_frame();
    rr_bad = 0;
    for (int i = 0; i < NUM_WIN; i++) if (grant_cu[i] != i % NUM_CU) rr_bad++;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: frame never completed"); end
    checks++; if (e0_start_zero !== 1'b1) begin errors++; $display("FAIL basic_e0_no_start: got %0b want 1", e0_start_zero); end
    checks++; if (e0_busy !== 1'b1) begin errors++; $display("FAIL basic_e0_busy: got %0b want 1", e0_busy); end
    checks++; if (grant_t[0] !== 1) begin errors++; $display("FAIL basic_first_latency: got %0d want 1", grant_t[0]); end
    checks++; if (n_grants !== 128) begin errors++; $display("FAIL basic_grants: got %0d want 128", n_grants); end
    checks++; if (n_order_bad !== 0) begin errors++; $display("FAIL basic_idx_order: got %0d bad want 0", n_order_bad); end
    checks++; if (n_addr_bad !== 0) begin errors++; $display("FAIL basic_addr: got %0d bad want 0", n_addr_bad); end
    checks++; if (last_addr !== 11'd1016) begin errors++; $display("FAIL basic_last_addr: got %0d want 1016", last_addr); end
    checks++; if (n_multi !== 0) begin errors++; $display("FAIL basic_onehot: got %0d bad want 0", n_multi); end
    checks++; if (n_overlap !== 0) begin errors++; $display("FAIL basic_overlap: got %0d want 0", n_overlap); end
    checks++; if (rr_bad !== 0) begin errors++; $display("FAIL basic_round_robin: got %0d bad want 0", rr_bad); end
    checks++; if (grant_t[127] !== 128) begin errors++; $display("FAIL basic_last_grant_t: got %0d want 128", grant_t[127]); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
    checks++; if (done_t !== 132) begin errors++; $display("FAIL basic_done_t: got %0d want 132", done_t); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %0b want 0", busy_at_done); end
    checks++; if (busy_before_done !== 1'b1) begin errors++; $display("FAIL basic_busy_before_done: got %0b want 1", busy_before_done); end
    checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %0b want 0", done_after); end
`ifdef RF_SCHED_PERF_EN
    checks++; if (perf_at_done !== 32'(done_t + 1)) begin errors++; $display("FAIL perf_count: got %0d want %0d", perf_at_done, done_t + 1); end
    checks++; if (perf_after_done !== 32'd133) begin errors++; $display("FAIL perf_hold: got %0d want 133", perf_after_done); end
`else
    checks++; if (n_perf_nz !== 0) begin errors++; $display("FAIL perf_zero: got %0d nonzero cycles want 0", n_perf_nz); end
`endif
  endtask

  task automatic test_slow_cu();
    int cu2_mid;
    set_lat(1, 1, 40, 1);
    run_frame();
    cu2_mid = 0;
    for (int i = 3; i <= 44; i++) if (grant_cu[i] == 2) cu2_mid++;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL slow_timeout: frame never completed"); end
    checks++; if (n_grants !== 128) begin errors++; $display("FAIL slow_grants: got %0d want 128", n_grants); end
    checks++; if (n_order_bad !== 0) begin errors++; $display("FAIL slow_idx_order: got %0d bad want 0", n_order_bad); end
    checks++; if (n_overlap !== 0) begin errors++; $display("FAIL slow_overlap: got %0d want 0", n_overlap); end
    checks++; if (grant_cu[2] !== 2) begin errors++; $display("FAIL slow_first_cu2: got %0d want 2", grant_cu[2]); end
    checks++; if (cu2_mid !== 0) begin errors++; $display("FAIL slow_cu2_skipped: got %0d grants want 0", cu2_mid); end
    checks++; if (grant_cu[45] !== 2) begin errors++; $display("FAIL slow_cu2_regrant: got %0d want 2", grant_cu[45]); end
    checks++; if (grant_t[45] !== 46) begin errors++; $display("FAIL slow_cu2_regrant_t: got %0d want 46", grant_t[45]); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL slow_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_dual_done();
    set_lat(30, 4, 30, 2);
    run_frame();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL dual_timeout: frame never completed"); end
    checks++; if (grant_t[3] !== 4) begin errors++; $display("FAIL dual_cu3_first_t: got %0d want 4", grant_t[3]); end
    checks++; if (grant_t[4] !== 7) begin errors++; $display("FAIL dual_idx4_t: got %0d want 7", grant_t[4]); end
    checks++; if (grant_cu[4] !== 1) begin errors++; $display("FAIL dual_idx4_cu: got %0d want 1", grant_cu[4]); end
    checks++; if (grant_t[5] !== 8) begin errors++; $display("FAIL dual_idx5_t: got %0d want 8", grant_t[5]); end
    checks++; if (grant_cu[5] !== 3) begin errors++; $display("FAIL dual_idx5_cu: got %0d want 3", grant_cu[5]); end
    checks++; if (n_grants !== 128) begin errors++; $display("FAIL dual_grants: got %0d want 128", n_grants); end
    checks++; if (n_overlap !== 0) begin errors++; $display("FAIL dual_overlap: got %0d want 0", n_overlap); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL dual_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_spurious();
    set_lat(1, 1, 1, 1);
    spur_t = 3;
    run_frame();
    checks++; if (err_pre !== 1'b0) begin errors++; $display("FAIL spur_err_before: got %0b want 0", err_pre); end
    checks++; if (err_post !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %0b want 1", err_post); end
    checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %0b want 1", err_at_done); end
    checks++; if (n_grants !== 128) begin errors++; $display("FAIL spur_grants: got %0d want 128", n_grants); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL spur_done_count: got %0d want 1", n_done); end
    set_lat(3, 3, 3, 3);
    run_frame();
    checks++; if (e0_err !== 1'b0) begin errors++; $display("FAIL spur_err_cleared: got %0b want 0", e0_err); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL spur_next_done: got %0d want 1", n_done); end
  endtask

  task automatic test_reset_mid();
    set_lat(3, 3, 3, 3);
    stop_mode = 1; stop_idx = 50;
    run_frame();
    checks++; if (stop_t !== 51) begin errors++; $display("FAIL rstmid_win50_t: got %0d want 51", stop_t); end
    checks++; if (rst_zero1 !== 1'b1) begin errors++; $display("FAIL rstmid_outputs_async: got %0b want 1", rst_zero1); end
    checks++; if (rst_zero2 !== 1'b1) begin errors++; $display("FAIL rstmid_outputs_held: got %0b want 1", rst_zero2); end
    set_lat(3, 3, 3, 3);
    run_frame();
    checks++; if (grant_t[0] !== 1 || grant_cu[0] !== 0) begin errors++; $display("FAIL rstmid_restart: got t=%0d cu=%0d want t=1 cu=0", grant_t[0], grant_cu[0]); end
    checks++; if (n_order_bad !== 0) begin errors++; $display("FAIL rstmid_order: got %0d bad want 0", n_order_bad); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL rstmid_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_abort();
    int busy_seen;
    set_lat(3, 3, 3, 3);
    stop_mode = 2; stop_idx = 50;
    run_frame();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL abort_window_reached: window 50 never issued"); end
    checks++; if (busy_after_abort !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy_after_abort); end
    checks++; if (n_start_after !== 0) begin errors++; $display("FAIL abort_no_dispatch: got %0d want 0", n_start_after); end
    checks++; if (n_done_after !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", n_done_after); end
    checks++; if (err_end !== 1'b1) begin errors++; $display("FAIL abort_late_done_err: got %0b want 1", err_end); end
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.busy || bus.cu_start != '0) busy_seen++;
      @(posedge clk); #1;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL abort_beats_start: got %0d active cycles want 0", busy_seen); end
    set_lat(3, 3, 3, 3);
    run_frame();
    checks++; if (e0_err !== 1'b0) begin errors++; $display("FAIL abort_restart_err: got %0b want 0", e0_err); end
    checks++; if (grant_cu[0] !== 0 || n_order_bad !== 0) begin errors++; $display("FAIL abort_restart_order: got cu=%0d bad=%0d want 0/0", grant_cu[0], n_order_bad); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL abort_restart_done: got %0d want 1", n_done); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cu_done = '0;
    test_reset();
    test_basic();
    test_slow_cu();
    test_dual_done();
    test_spurious();
    test_reset_mid();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
